// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer
// and its hazard detection helpers.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TIMEOUT  = 2'd2
  } state_t;

  localparam logic [4:0] REG_ZERO         = 5'd0;
  localparam int         DEFAULT_MAX_WAIT = 16;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use compare between the ID source registers and the
// destination of a load sitting in EX.
import pipe_ctrl_pkg::*;

module hazard_detect (
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic       i_id_uses_rs1,
  input  logic       i_id_uses_rs2,
  input  logic [4:0] i_ex_rd,
  input  logic       i_ex_mem_read,
  output logic       o_load_use
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  // x0 is never a real producer, so a load targeting it cannot cause a hazard
  assign w_rs1_hit  = i_id_uses_rs1 && (i_id_rs1 == i_ex_rd);
  assign w_rs2_hit  = i_id_uses_rs2 && (i_id_rs2 == i_ex_rd);
  assign o_load_use = i_ex_mem_read && (i_ex_rd != REG_ZERO) && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: arbitrates memory wait,
// taken branches and load-use hazards, with a memory-wait watchdog.
import pipe_ctrl_pkg::*;

module pipeline_ctrl #(
  parameter int MAX_WAIT = DEFAULT_MAX_WAIT,
  parameter int WAIT_W   = 5,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             mem_wb_bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [WAIT_W-1:0]   w_wait_nxt;
  logic                r_mem_timeout;
  logic                w_timeout_nxt;
  logic [CNT_W-1:0]    r_stall_cnt;
  logic                w_mem_stall;
  logic                w_load_use;

  assign w_mem_stall = mem_req && !mem_ready;

  hazard_detect u_hazard_detect (
    .i_id_rs1      (id_rs1),
    .i_id_rs2      (id_rs2),
    .i_id_uses_rs1 (id_uses_rs1),
    .i_id_uses_rs2 (id_uses_rs2),
    .i_ex_rd       (ex_rd),
    .i_ex_mem_read (ex_mem_read),
    .o_load_use    (w_load_use)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= RUN;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_wait_cnt    <= w_wait_nxt;
      r_mem_timeout <= w_timeout_nxt;
    end
  end

  // The first stalled cycle is spent in RUN, so MEM_WAIT trips the watchdog
  // when it sees the MAX_WAIT-th consecutive stall.
  always_comb begin
    w_state_nxt   = r_state;
    w_wait_nxt    = r_wait_cnt;
    w_timeout_nxt = r_mem_timeout;
    case (r_state)
      RUN: begin
        if (w_mem_stall) begin
          w_state_nxt = MEM_WAIT;
          w_wait_nxt  = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (w_mem_stall) begin
          if (r_wait_cnt == WAIT_W'(MAX_WAIT - 1)) begin
            w_state_nxt   = TIMEOUT;
            w_timeout_nxt = 1'b1;
          end else begin
            w_wait_nxt = r_wait_cnt + WAIT_W'(1);
          end
        end else begin
          w_state_nxt = RUN;
          w_wait_nxt  = '0;
        end
      end
      TIMEOUT: begin
        w_timeout_nxt = 1'b1;
      end
      default: begin
        w_state_nxt = RUN;
        w_wait_nxt  = '0;
      end
    endcase
  end

  always_comb begin
    pc_en         = 1'b0;
    if_id_en      = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_en      = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_en     = 1'b0;
    mem_wb_en     = 1'b0;
    mem_wb_bubble = 1'b0;
    if (!rst && (r_state != TIMEOUT)) begin
      if (w_mem_stall) begin
        // WB retires a bubble so the held MEM result is not written twice
        mem_wb_en     = 1'b1;
        mem_wb_bubble = 1'b1;
      end else if (ex_branch_taken) begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b1;
        id_ex_en    = 1'b1;
        id_ex_flush = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
      end else if (w_load_use) begin
        id_ex_en    = 1'b1;
        id_ex_flush = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
      end else begin
        pc_en     = 1'b1;
        if_id_en  = 1'b1;
        id_ex_en  = 1'b1;
        ex_mem_en = 1'b1;
        mem_wb_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (!pc_en && !(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign mem_timeout = r_mem_timeout;
  assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized
// traffic against a run-length behavioural model.
module tb_pipeline_ctrl;

  localparam int MAX_WAIT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
  logic        mem_req, mem_ready;
  logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic        ex_mem_en, mem_wb_en, mem_wb_bubble, mem_timeout;
  logic [31:0] stall_cnt;
  logic        pc_en4, if_id_en4, if_id_flush4, id_ex_en4, id_ex_flush4;
  logic        ex_mem_en4, mem_wb_en4, mem_wb_bubble4, mem_timeout4;
  logic [3:0]  stall_cnt4;

  int checks = 0;
  int errors = 0;

  // model state: consecutive stalled cycles, timed-out flag, total pc_en=0 cycles
  int   m_run = 0;
  bit   m_to  = 1'b0;
  int   m_cnt = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.MAX_WAIT(MAX_WAIT), .WAIT_W(5), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_en(pc_en),
    .if_id_en(if_id_en), .if_id_flush(if_id_flush), .id_ex_en(id_ex_en),
    .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .mem_wb_bubble(mem_wb_bubble), .mem_timeout(mem_timeout), .stall_cnt(stall_cnt)
  );

  pipeline_ctrl #(.MAX_WAIT(MAX_WAIT), .WAIT_W(5), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_en(pc_en4),
    .if_id_en(if_id_en4), .if_id_flush(if_id_flush4), .id_ex_en(id_ex_en4),
    .id_ex_flush(id_ex_flush4), .ex_mem_en(ex_mem_en4), .mem_wb_en(mem_wb_en4),
    .mem_wb_bubble(mem_wb_bubble4), .mem_timeout(mem_timeout4), .stall_cnt(stall_cnt4)
  );

  // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en, mem_wb_bubble, mem_timeout}
  function automatic logic [8:0] model_out();
    bit ms, lu;
    ms = mem_req && !mem_ready;
    lu = ex_mem_read && (ex_rd != 5'd0) &&
         ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    if (rst)                  return {8'b0, m_to};
    else if (m_to)            return 9'b000000001;
    else if (ms)              return 9'b000000110;
    else if (ex_branch_taken) return 9'b111111100;
    else if (lu)              return 9'b000111100;
    else                      return 9'b110101100;
  endfunction

  function automatic logic [44:0] model_all();
    logic [3:0] c4;
    c4 = (m_cnt > 15) ? 4'd15 : 4'(m_cnt);
    return {model_out(), 32'(m_cnt), c4};
  endfunction

  function automatic logic [44:0] dut_all();
    return {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
            mem_wb_en, mem_wb_bubble, mem_timeout, stall_cnt, stall_cnt4};
  endfunction

  task automatic set_idle();
    rst = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_rd = 5'd0; ex_mem_read = 1'b0; ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  // Advances one clock and applies the architectural effect of that cycle to the model.
  task automatic tick();
    logic [8:0] e;
    @(posedge clk);
    e = model_out();
    if (rst) begin
      m_run = 0; m_to = 1'b0; m_cnt = 0;
    end else begin
      if (!e[8]) m_cnt++;
      if (!m_to) begin
        if (mem_req && !mem_ready) begin
          m_run++;
          if (m_run >= MAX_WAIT) m_to = 1'b1;
        end else begin
          m_run = 0;
        end
      end
    end
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1'b1;
    tick();
    checks++;
    if (dut_all() !== model_all()) begin
      errors++; $display("FAIL reset_hold got=%h exp=%h", dut_all(), model_all());
    end
    rst = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (dut_all() !== model_all()) begin
        errors++; $display("FAIL reset_idle%0d got=%h exp=%h", i, dut_all(), model_all());
      end
      tick();
    end
    checks++;
    if ({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, mem_timeout, stall_cnt} !== {8'b11111000, 32'd0}) begin
      errors++; $display("FAIL reset_const pc_en=%b stall_cnt=%0d exp pc_en=1 stall_cnt=0", pc_en, stall_cnt);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1; id_rs1 = 5'd3; id_uses_rs1 = 1'b1;
    #1;
    checks++;
    if (dut_all() !== model_all()) begin
      errors++; $display("FAIL load_use_hit got=%h exp=%h", dut_all(), model_all());
    end
    checks++;
    if ({pc_en, if_id_en, id_ex_flush} !== 3'b001) begin
      errors++; $display("FAIL load_use_const got=%b exp=001", {pc_en, if_id_en, id_ex_flush});
    end
    tick();
    set_idle();
    #1;
    checks++;
    if (dut_all() !== model_all() || stall_cnt !== 32'd1 || pc_en !== 1'b1) begin
      errors++; $display("FAIL load_use_after got=%h exp=%h stall_cnt=%0d exp 1", dut_all(), model_all(), stall_cnt);
    end
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0; id_uses_rs2 = 1'b1;
    #1;
    checks++;
    if (dut_all() !== model_all() || pc_en !== 1'b1 || id_ex_flush !== 1'b0) begin
      errors++; $display("FAIL load_use_x0 got=%h exp=%h", dut_all(), model_all());
    end
    tick();
  endtask

  task automatic test_branch();
    set_idle();
    ex_branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b1;
    #1;
    checks++;
    if (dut_all() !== model_all() || {pc_en, if_id_flush, id_ex_flush} !== 3'b111) begin
      errors++; $display("FAIL branch_lu got=%h exp=%h", dut_all(), model_all());
    end
    tick();
    set_idle();
    #1;
    checks++;
    if (dut_all() !== model_all() || stall_cnt !== 32'd1) begin
      errors++; $display("FAIL branch_cnt got=%h exp=%h stall_cnt=%0d exp 1", dut_all(), model_all(), stall_cnt);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      mem_req = 1'b1; mem_ready = 1'b0; ex_branch_taken = (i == 1);
      #1;
      checks++;
      if (dut_all() !== model_all() || {pc_en, mem_wb_en, mem_wb_bubble} !== 3'b011) begin
        errors++; $display("FAIL mem_wait%0d got=%h exp=%h", i, dut_all(), model_all());
      end
      tick();
    end
    mem_ready = 1'b1; ex_branch_taken = 1'b1;
    #1;
    checks++;
    if (dut_all() !== model_all() || {pc_en, if_id_flush, id_ex_flush, mem_wb_bubble} !== 4'b1110) begin
      errors++; $display("FAIL mem_release got=%h exp=%h", dut_all(), model_all());
    end
    tick();
    set_idle();
    #1;
    checks++;
    if (dut_all() !== model_all() || stall_cnt !== 32'd3) begin
      errors++; $display("FAIL mem_wait_cnt stall_cnt=%0d exp 3", stall_cnt);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < MAX_WAIT - 1; i++) begin
      mem_req = 1'b1; mem_ready = 1'b0;
      tick();
    end
    mem_ready = 1'b1;
    tick();
    set_idle();
    #1;
    checks++;
    if (dut_all() !== model_all() || mem_timeout !== 1'b0 || pc_en !== 1'b1) begin
      errors++; $display("FAIL wait_15_no_timeout got=%h exp=%h", dut_all(), model_all());
    end
    do_reset();
    for (int i = 0; i < 20; i++) begin
      mem_req = 1'b1; mem_ready = 1'b0;
      #1;
      checks++;
      if (dut_all() !== model_all() || mem_timeout !== (i >= MAX_WAIT)) begin
        errors++; $display("FAIL timeout_cyc%0d got=%h exp=%h", i, dut_all(), model_all());
      end
      tick();
    end
    set_idle();
    mem_req = 1'b1; mem_ready = 1'b1; ex_branch_taken = 1'b1;
    #1;
    checks++;
    if (dut_all() !== model_all() || {mem_timeout, pc_en, mem_wb_en} !== 3'b100) begin
      errors++; $display("FAIL timeout_sticky got=%h exp=%h", dut_all(), model_all());
    end
    tick();
  endtask

  task automatic test_reset_timeout_sat();
    set_idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (dut_all() !== model_all() || {mem_timeout, pc_en, stall_cnt} !== {2'b01, 32'd0}) begin
      errors++; $display("FAIL rst_from_timeout got=%h exp=%h", dut_all(), model_all());
    end
    for (int i = 0; i < 20; i++) begin
      ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_uses_rs1 = 1'b1;
      tick();
      set_idle();
      tick();
    end
    checks++;
    if (dut_all() !== model_all() || stall_cnt4 !== 4'd15 || stall_cnt !== 32'd20) begin
      errors++; $display("FAIL saturate cnt4=%0d cnt=%0d exp 15 20", stall_cnt4, stall_cnt);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      bit slow;
      slow = (i >= 300);
      rst             = ($urandom_range(0, 79) == 0);
      id_rs1          = 5'($urandom_range(0, 6));
      id_rs2          = 5'($urandom_range(0, 6));
      id_uses_rs1     = 1'($urandom);
      id_uses_rs2     = 1'($urandom);
      ex_rd           = 5'($urandom_range(0, 6));
      ex_mem_read     = 1'($urandom);
      ex_branch_taken = ($urandom_range(0, 3) == 0);
      mem_req         = slow ? ($urandom_range(0, 15) != 0) : 1'($urandom);
      mem_ready       = slow ? ($urandom_range(0, 11) == 0) : 1'($urandom);
      #1;
      checks++;
      if (dut_all() !== model_all()) begin
        errors++; $display("FAIL random%0d got=%h exp=%h", i, dut_all(), model_all());
      end
      tick();
    end
  endtask

  initial begin
    set_idle();
    @(negedge clk);
    #1;
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_reset_timeout_sat();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central stall/flush sequencer for the RV32I 5-stage pipeline. It drives the enable and flush inputs of PC, IF_ID, ID_EX, EX_MEM and MEM_WB. It resolves three conditions: data-memory wait, taken branch/jump in EX, and load-use hazard. It also tracks memory-wait duration with a watchdog and counts stall cycles for performance.

Parameters:
MAX_WAIT, 16, max consecutive memory-wait cycles before timeout (>=2)
WAIT_W, 5, width of wait counter (must hold MAX_WAIT)
CNT_W, 32, width of stall performance counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
id_rs1  in  5  rs1 of instruction in ID
id_rs2  in  5  rs2 of instruction in ID
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_rd  in  5  rd of instruction in EX
ex_mem_read  in  1  EX instruction is a load
ex_branch_taken  in  1  EX resolved taken branch/jal/jalr
mem_req  in  1  MEM stage has an active data-memory access
mem_ready  in  1  data memory completes access this cycle
pc_en  out  1  PC update enable
if_id_en  out  1  IF_ID enable
if_id_flush  out  1  IF_ID clear to NOP
id_ex_en  out  1  ID_EX enable
id_ex_flush  out  1  ID_EX clear to bubble
ex_mem_en  out  1  EX_MEM enable
mem_wb_en  out  1  MEM_WB enable
mem_wb_bubble  out  1  MEM_WB loads bubble (reg_wr=0) instead of MEM data
mem_timeout  out  1  sticky watchdog error
stall_cnt  out  CNT_W  saturating count of cycles with pc_en=0

Behaviour:
- All control outputs are combinational from inputs and state. Counters and state are registered.
- Reset (rst=1 at posedge): state<=RUN, wait_cnt<=0, stall_cnt<=0, mem_timeout<=0. While rst=1, all *_en=0, all flush/bubble=0.
- FSM states: RUN, MEM_WAIT, TIMEOUT.
- Define mem_stall = mem_req & ~mem_ready.
- Define load_use = ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- Priority, highest first: TIMEOUT > mem_stall > ex_branch_taken > load_use > normal.
- TIMEOUT: all *_en=0, flushes=0, mem_timeout=1. The block stays in this state until rst.
- mem_stall:
  - pc_en, if_id_en, id_ex_en, ex_mem_en = 0.
  - mem_wb_en=1 with mem_wb_bubble=1, so WB retires a no-op and never double-writes.
  - Branch and load_use are ignored this cycle; EX is held, so both re-evaluate after release.
- ex_branch_taken (no mem_stall): all en=1, if_id_flush=1, id_ex_flush=1. Two-instruction penalty. A simultaneous load_use is ignored because the ID instruction is squashed.
- load_use only: pc_en=0, if_id_en=0, id_ex_en=1 with id_ex_flush=1, ex_mem_en=1, mem_wb_en=1. Exactly one bubble; next cycle ex_mem_read is gone and the pipeline resumes.
- Normal: all en=1, flush/bubble=0.
- State transitions:
  - RUN -> MEM_WAIT when mem_stall; wait_cnt<=1.
  - MEM_WAIT with mem_stall: wait_cnt increments. When wait_cnt==MAX_WAIT-1 at the posedge, go to TIMEOUT (mem_timeout=1).
  - MEM_WAIT with mem_ready: go to RUN, wait_cnt<=0. The release cycle uses normal/branch/load_use rules.
  - A stall of exactly MAX_WAIT-1 cycles followed by mem_ready does not time out.
- stall_cnt increments on every non-reset cycle with pc_en=0, including TIMEOUT. It saturates at all-ones and never wraps.
- Any rst assertion mid-stall or in TIMEOUT returns to RUN next cycle with all counters cleared.

Decomposition:
- Package pipe_ctrl_pkg: state enum {RUN, MEM_WAIT, TIMEOUT}, REG_ZERO=5'd0, default MAX_WAIT.
- Sub-module hazard_detect: purely combinational load_use compare, reusable for the forwarding unit.
- FSM, watchdog and counters stay in pipeline_ctrl.

Test Plan:
1. Reset then idle inputs for 3 cycles -> all en=1, flush=0, stall_cnt=0, mem_timeout=0.
2. ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 for one cycle -> pc_en=0, if_id_en=0, id_ex_flush=1; next cycle normal; stall_cnt=1. Repeat with ex_rd=0 -> no stall.
3. ex_branch_taken=1 with a simultaneous load_use match -> if_id_flush=1, id_ex_flush=1, pc_en=1; stall_cnt unchanged.
4. mem_req=1, mem_ready=0 for 3 cycles then mem_ready=1 -> 3 cycles of all en=0 except mem_wb_en=1 with mem_wb_bubble=1, state returns to RUN, stall_cnt=3; branch asserted during the wait is honored only on the release cycle.
5. mem_req=1, mem_ready=0 held 20 cycles (MAX_WAIT=16) -> mem_timeout=1 after 16 stalled cycles and stays high; 15-cycle wait then ready -> no timeout.
6. rst=1 asserted while in TIMEOUT -> next cycle state=RUN, mem_timeout=0, stall_cnt=0; pulse test with CNT_W=4 confirms stall_cnt saturates at 15.
